// File: rtl/mul_scheduler_pkg.sv
// Shared constants and helpers for the multiplier scheduler slice.
package mul_sched_pkg;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;

  typedef logic [3:0] phase_t;

  localparam phase_t LAST_PHASE = 4'd9;

  // Ten-phase slot counter: 0..LAST_PHASE then back to 0.
  function automatic phase_t next_phase(phase_t p);
    return (p == LAST_PHASE) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/mul_scheduler_if.sv
// Request/response bundle between clients (master) and the scheduler (slave).
interface mul_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import mul_sched_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*MUL_W-1:0] req_a;
  logic [NUM_REQ*MUL_W-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [PROD_W-1:0]        resp_data;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_id, resp_data, busy
  );

endinterface

// File: rtl/mul_scheduler_multiplier.sv
// Free-running 8x8 shift-add multiplier: samples in1/in2 at the end of
// phase 0, performs one add/shift step in each of phases 1..8, and presents
// the finished product on out throughout phase 9.
module multiplier
  import mul_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MUL_W-1:0]  in1,
  input  logic [MUL_W-1:0]  in2,
  output logic [PROD_W-1:0] out
);

  phase_t             mphase_q, mphase_d;
  logic [PROD_W-1:0]  a_sh_q, a_sh_d;
  logic [MUL_W-1:0]   b_sh_q, b_sh_d;
  logic [PROD_W-1:0]  acc_q, acc_d;

  // Load operands in phase 0, then one partial-product step per phase 1..8.
  always_comb begin
    mphase_d = next_phase(mphase_q);
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    if (mphase_q == 4'd0) begin
      a_sh_d = {{(PROD_W-MUL_W){1'b0}}, in1};
      b_sh_d = in2;
      acc_d  = '0;
    end else if (mphase_q != LAST_PHASE) begin
      if (b_sh_q[0]) begin
        acc_d = acc_q + a_sh_q;
      end
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
    end
  end

  // Only the phase counter is reset; the datapath is reloaded every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      mphase_q <= 4'd0;
    end else begin
      mphase_q <= mphase_d;
    end
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
    acc_q  <= acc_d;
  end

  assign out = acc_q;

endmodule

// File: rtl/mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 (mod N) and
// returns the first requesting index as one-hot grant plus encoded id.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id,
  output logic            found
);

  logic [ID_W-1:0] idx;

  // Walk the N candidates in rotated priority order, keep the first hit.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Time-shares one sequential multiplier among NUM_REQ requesters. A local
// phase counter mirrors the multiplier's 10-cycle slot; one round-robin
// grant is made in phase 9, and the previous slot's product is returned
// tagged with its requester id on the same edge.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst,
  mul_scheduler_if.slave  bus
);

  phase_t             phase_q, phase_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    slot_id_q, slot_id_d;
  logic               slot_valid_q, slot_valid_d;
  logic [MUL_W-1:0]   op_a_q, op_a_d;
  logic [MUL_W-1:0]   op_b_q, op_b_d;
  logic               resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [PROD_W-1:0]  resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_id;
  logic               arb_found;
  logic               at_last;
  logic               accept;
  logic [MUL_W-1:0]   sel_a, sel_b;
  logic [PROD_W-1:0]  mul_out;

  // The grant window is the single phase-9 cycle of each slot.
  assign at_last = (phase_q == LAST_PHASE) && !rst;
  assign accept  = at_last && arb_found;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .last  (last_grant_q),
    .grant (arb_grant),
    .id    (arb_id),
    .found (arb_found)
  );

  multiplier u_mul (
    .clk (clk),
    .rst (rst),
    .in1 (op_a_q),
    .in2 (op_b_q),
    .out (mul_out)
  );

  // Mux the granted requester's operands out of the packed buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_a = bus.req_a[i*MUL_W +: MUL_W];
        sel_b = bus.req_b[i*MUL_W +: MUL_W];
      end
    end
  end

  // Slot bookkeeping: capture the finished slot, then load the next grant.
  always_comb begin
    phase_d      = next_phase(phase_q);
    last_grant_d = last_grant_q;
    slot_id_d    = slot_id_q;
    slot_valid_d = slot_valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    if (at_last) begin
      resp_valid_d = slot_valid_q;
      resp_data_d  = mul_out;
      resp_id_d    = slot_id_q;
      if (accept) begin
        op_a_d       = sel_a;
        op_b_d       = sel_b;
        slot_id_d    = arb_id;
        slot_valid_d = 1'b1;
        last_grant_d = arb_id;
      end else begin
        op_a_d       = '0;
        op_b_d       = '0;
        slot_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any in-flight slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= 4'd0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      slot_id_q    <= '0;
      slot_valid_q <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      phase_q      <= phase_d;
      last_grant_q <= last_grant_d;
      slot_id_q    <= slot_id_d;
      slot_valid_q <= slot_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ready  = at_last ? arb_grant : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = slot_valid_q;

endmodule
